kmeans_point_ram_ctrl: RTL and testbench
========================================

Name: kmeans_point_ram_ctrl

Overview:
- Sits directly downstream of the register file; consumes its single-cycle RAM-write pulses (w_r_ram with data2core/address2core) and owns the single-port point SRAM.
- Buffers host writes in a small FIFO, serves the k-means core's streaming point reads, and performs a full-memory clear on request.
- Drives one SRAM access per cycle; arbitrates between clear, buffered writes and core reads.

Parameters:
- DATA_W, 91, width of one point word, equal to the register file data width.
- ADDR_W, 10, SRAM address width; DEPTH = 2**ADDR_W.
- FIFO_DEPTH, 4, host-write buffer entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- hw_valid  in  1  host write pulse, driven by the register file's w_r_ram
- hw_addr  in  DATA_W  host write address, driven by address2core
- hw_data  in  DATA_W  host write data, driven by data2core
- go  in  1  core run, driven by go_core; clear is refused while high
- clr_start  in  1  one-cycle pulse; zero the whole SRAM
- rd_req_valid  in  1  core read request
- rd_req_ready  out  1  request accepted this cycle
- rd_addr  in  ADDR_W  core read address
- rd_data_valid  out  1  read data strobe
- rd_data  out  DATA_W  read data
- busy  out  1  clear in progress or FIFO non-empty
- err_ovf  out  1  sticky: host write dropped because the FIFO was full
- err_addr  out  1  sticky: host write dropped because hw_addr >= DEPTH
- wr_count  out  ADDR_W+1  number of host writes committed to SRAM, saturating
- mem_ce  out  1  SRAM chip enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid one cycle after a read with mem_ce=1, mem_we=0

Behaviour:
- Reset is rst_n, synchronous, active-low, on clock clk.
- Reset values:
  - All outputs 0, except rd_req_ready, which follows its combinational rule.
  - FIFO emptied; FSM in IDLE.
  - Reset mid-clear abandons the clear. Memory contents are undefined afterwards.
- Host write intake, on hw_valid=1:
  - If hw_addr[DATA_W-1:ADDR_W] is non-zero: drop the write and set err_addr.
  - Else if the FIFO is full: drop the write and set err_ovf.
  - Else: push {hw_addr[ADDR_W-1:0], hw_data}.
  - Intake operates in every state, including CLEAR.
  - A push and a pop in the same cycle while full is a drop; full is evaluated before the pop.
- FSM states: IDLE, CLEAR.
  - IDLE to CLEAR: clr_start=1 and go=0. clr_start while go=1 is ignored.
  - CLEAR:
    - Writes 0 to address clr_ptr, incrementing 0..DEPTH-1, one per cycle.
    - Returns to IDLE after writing DEPTH-1.
    - Takes DEPTH cycles.
    - Has highest port priority; the FIFO holds and reads stall.
    - A second clr_start during CLEAR is ignored.
    - The clear also resets wr_count to 0 on entry.
- IDLE port priority per cycle:
  1. FIFO non-empty: pop one entry and issue the write (mem_ce=1, mem_we=1). wr_count is incremented, saturating at DEPTH.
  2. Otherwise, a read when rd_req_valid=1.
- rd_req_ready:
  - 1 only when state=IDLE, FIFO empty and not in reset.
  - It is combinational from registered state.
  - It does not depend on rd_req_valid.
- Read latency:
  - Request accepted in cycle N.
  - rd_data_valid=1 with rd_data in cycle N+2: SRAM 1 cycle plus an output register.
  - Back-to-back reads give one result per cycle, in order.
- Read-after-write ordering:
  - A write popped in cycle M is visible to a read accepted in cycle M+1 or later.
  - Reads are never accepted while earlier host writes are still buffered.
- busy = (state==CLEAR) | FIFO non-empty.
- err_ovf and err_addr clear only on reset.

Optional Feature:
- Macro: KMEANS_RAM_RD_PIPE_EN.
- When defined:
  - Adds a second register stage on rd_data and rd_data_valid.
  - Read latency becomes N+3; throughput is unchanged.
- When undefined: latency is N+2 as specified above.

Decomposition:
- Package kmeans_pkg holds:
  - constants KM_DATA_W=91 and KM_ADDR_W=10;
  - typedef km_point_t as logic [KM_DATA_W-1:0];
  - enum ram_ctrl_st_e {IDLE, CLEAR}.
- One sub-module: km_sync_fifo (parameterised width/depth, push/pop/full/empty, registered storage), instantiated for the host-write buffer.

Test Plan:
- Single write then read:
  - Stimulus: hw_valid with addr 5, data 91'h1234; after busy=0, read addr 5.
  - Response: mem write to 5 one cycle after the pulse; rd_data=91'h1234 at accept+2; wr_count=1.
- Overflow:
  - Stimulus: 6 hw_valid pulses on consecutive cycles while a clear is running.
  - Response: 4 buffered; err_ovf=1 on the 5th pulse; after the clear completes, exactly 4 writes drain in order.
- Bad address:
  - Stimulus: hw_addr=1024 with ADDR_W=10.
  - Response: no mem_we; err_addr=1; wr_count unchanged.
- Clear:
  - Stimulus: clr_start with go=0.
  - Response: busy stays high for 1024 cycles; mem_we with addr 0..1023 and wdata 0; a subsequent read returns 0.
  - Stimulus: clr_start with go=1.
  - Response: ignored.
- Arbitration and ordering:
  - Stimulus: rd_req_valid held at addr 7 while a host write to 7 of 91'hABC arrives.
  - Response: rd_req_ready=0 until the FIFO is empty; the read returns 91'hABC.
  - Stimulus: 8 back-to-back reads.
  - Response: 8 consecutive rd_data_valid cycles.
- Reset mid-clear and pipe option:
  - Stimulus: rst_n=0 at clear cycle 100.
  - Response: state IDLE; all flags and wr_count 0.
  - Stimulus: same read-latency test with KMEANS_RAM_RD_PIPE_EN defined.
  - Response: data at accept+3.

Source files
------------

// File: rtl/kmeans_pkg.sv
// Shared widths, point type and controller state encoding for the k-means point RAM controller.
package kmeans_pkg;

  localparam int KM_DATA_W = 91;
  localparam int KM_ADDR_W = 10;

  typedef logic [KM_DATA_W-1:0] km_point_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ram_ctrl_st_e;

endpackage

// File: rtl/km_sync_fifo.sv
// Small synchronous FIFO with registered storage and first-word-fall-through read.
// Pushes while full and pops while empty are ignored.
module km_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // The extra pointer MSB distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/kmeans_point_ram_ctrl.sv
// Point SRAM controller: buffers host writes, serves core streaming reads, clears the SRAM on request.
// Optional KMEANS_RAM_RD_PIPE_EN adds a second output register on the read data path.
module kmeans_point_ram_ctrl
  import kmeans_pkg::*;
#(
  parameter int DATA_W     = KM_DATA_W,
  parameter int ADDR_W     = KM_ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hw_valid,
  input  logic [DATA_W-1:0] hw_addr,
  input  logic [DATA_W-1:0] hw_data,
  input  logic              go,
  input  logic              clr_start,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              err_ovf,
  output logic              err_addr,
  output logic [ADDR_W:0]   wr_count,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [ADDR_W:0]   WR_CNT_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   WR_CNT_ONE = 1;
  localparam logic [ADDR_W-1:0] CLR_ONE    = 1;
  localparam logic [ADDR_W-1:0] CLR_LAST   = '1;

  ram_ctrl_st_e      state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [ADDR_W:0]   wr_count_q, wr_count_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_addr_q, err_addr_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              addr_bad;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ENT_W-1:0]  fifo_wdata;
  logic [ENT_W-1:0]  fifo_rdata;
  logic              rd_accept;

  // Intake: full is sampled before any pop this cycle, so push+pop while full drops.
  assign addr_bad   = |hw_addr[DATA_W-1:ADDR_W];
  assign fifo_push  = hw_valid & ~addr_bad & ~fifo_full;
  assign fifo_wdata = {hw_addr[ADDR_W-1:0], hw_data};

  km_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rd_req_ready = rst_n && (state_q == IDLE) && fifo_empty;
  assign rd_accept    = rd_req_valid & rd_req_ready;
  assign busy         = rst_n && ((state_q == CLEAR) || !fifo_empty);

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    wr_count_d = wr_count_q;
    fifo_pop   = 1'b0;
    mem_ce     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            mem_ce    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = fifo_rdata[DATA_W +: ADDR_W];
            mem_wdata = fifo_rdata[DATA_W-1:0];
            if (wr_count_q != WR_CNT_MAX) begin
              wr_count_d = wr_count_q + WR_CNT_ONE;
            end
          end else if (rd_accept) begin
            mem_ce   = 1'b1;
            mem_addr = rd_addr;
          end
          if (clr_start && !go) begin
            state_d    = CLEAR;
            clr_ptr_d  = '0;
            wr_count_d = '0;
          end
        end
        CLEAR: begin
          mem_ce    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = clr_ptr_q;
          clr_ptr_d = clr_ptr_q + CLR_ONE;
          if (clr_ptr_q == CLR_LAST) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Errors are sticky; read data is captured one cycle after the SRAM access.
  always_comb begin
    err_addr_d = err_addr_q | (hw_valid & addr_bad);
    err_ovf_d  = err_ovf_q | (hw_valid & ~addr_bad & fifo_full);
    rd_pend_d  = rd_accept;
    rd_vld_d   = rd_pend_q;
    rd_data_d  = rd_pend_q ? mem_rdata : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clr_ptr_q  <= '0;
      wr_count_q <= '0;
      err_ovf_q  <= 1'b0;
      err_addr_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      wr_count_q <= wr_count_d;
      err_ovf_q  <= err_ovf_d;
      err_addr_q <= err_addr_d;
      rd_pend_q  <= rd_pend_d;
      rd_vld_q   <= rd_vld_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign err_ovf  = err_ovf_q;
  assign err_addr = err_addr_q;
  assign wr_count = wr_count_q;

`ifdef KMEANS_RAM_RD_PIPE_EN
  logic              rd_vld2_q, rd_vld2_d;
  logic [DATA_W-1:0] rd_data2_q, rd_data2_d;

  always_comb begin
    rd_vld2_d  = rd_vld_q;
    rd_data2_d = rd_vld_q ? rd_data_q : rd_data2_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld2_q  <= 1'b0;
      rd_data2_q <= '0;
    end else begin
      rd_vld2_q  <= rd_vld2_d;
      rd_data2_q <= rd_data2_d;
    end
  end

  assign rd_data_valid = rd_vld2_q;
  assign rd_data       = rd_data2_q;
`else
  assign rd_data_valid = rd_vld_q;
  assign rd_data       = rd_data_q;
`endif

endmodule

// File: tb/tb_kmeans_point_ram_ctrl.sv
// Randomized self-checking bench for kmeans_point_ram_ctrl against a queue-based reference model.
module tb_kmeans_point_ram_ctrl;

  localparam int DW    = 91;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;
  localparam int FDEP  = 4;
`ifdef KMEANS_RAM_RD_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hw_valid = 1'b0;
  logic [DW-1:0] hw_addr = '0;
  logic [DW-1:0] hw_data = '0;
  logic          go = 1'b0;
  logic          clr_start = 1'b0;
  logic          rd_req_valid = 1'b0;
  logic          rd_req_ready;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_data_valid;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          err_ovf;
  logic          err_addr;
  logic [AW:0]   wr_count;
  logic          mem_ce;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  kmeans_point_ram_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hw_valid      (hw_valid),
    .hw_addr       (hw_addr),
    .hw_data       (hw_data),
    .go            (go),
    .clr_start     (clr_start),
    .rd_req_valid  (rd_req_valid),
    .rd_req_ready  (rd_req_ready),
    .rd_addr       (rd_addr),
    .rd_data_valid (rd_data_valid),
    .rd_data       (rd_data),
    .busy          (busy),
    .err_ovf       (err_ovf),
    .err_addr      (err_addr),
    .wr_count      (wr_count),
    .mem_ce        (mem_ce),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  // Single-port SRAM attached to the controller.
  logic [DW-1:0] sram [DEPTH];
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  // Reference model state.
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { int due; logic [DW-1:0] d; } rd_t;
  logic [DW-1:0] m_mem [DEPTH];
  wr_t           m_fifo [$];
  rd_t           m_rdq [$];
  int            m_clr_left = 0;
  bit            m_ovf = 1'b0;
  bit            m_aerr = 1'b0;
  int            m_wcnt = 0;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic step(input logic hv, input logic [DW-1:0] ha, input logic [DW-1:0] hd,
                      input logic g, input logic cs, input logic rv, input logic [AW-1:0] ra);
    bit  clearing, fifo_ne, acc;
    int  sz0;
    wr_t w;
    hw_valid = hv; hw_addr = ha; hw_data = hd;
    go = g; clr_start = cs; rd_req_valid = rv; rd_addr = ra;
    @(negedge clk);
    clearing = (m_clr_left > 0);
    sz0      = m_fifo.size();
    fifo_ne  = (sz0 > 0);
    acc      = !clearing && !fifo_ne && rv;
    chk("rd_req_ready", 128'(rd_req_ready), 128'(!clearing && !fifo_ne));
    chk("busy", 128'(busy), 128'(clearing || fifo_ne));
    chk("mem_we", 128'(mem_we), 128'(clearing || fifo_ne));
    chk("mem_ce", 128'(mem_ce), 128'(clearing || fifo_ne || acc));
    if (clearing) begin
      chk("clr_addr", 128'(mem_addr), 128'(DEPTH - m_clr_left));
      chk("clr_wdata", 128'(mem_wdata), 128'(0));
    end else if (fifo_ne) begin
      chk("wr_addr", 128'(mem_addr), 128'(m_fifo[0].a));
      chk("wr_wdata", 128'(mem_wdata), 128'(m_fifo[0].d));
    end else if (acc) begin
      chk("rd_mem_addr", 128'(mem_addr), 128'(ra));
    end
    if (m_rdq.size() > 0 && m_rdq[0].due == cyc) begin
      chk("rd_data_valid", 128'(rd_data_valid), 128'(1));
      chk("rd_data", 128'(rd_data), 128'(m_rdq[0].d));
      $display("read  cyc=%0d data=%0h expected=%0h", cyc, rd_data, m_rdq[0].d);
      void'(m_rdq.pop_front());
    end else begin
      chk("rd_data_valid", 128'(rd_data_valid), 128'(0));
    end
    chk("err_ovf", 128'(err_ovf), 128'(m_ovf));
    chk("err_addr", 128'(err_addr), 128'(m_aerr));
    chk("wr_count", 128'(wr_count), 128'(m_wcnt));
    // Advance the model by one cycle.
    if (clearing) begin
      m_mem[DEPTH - m_clr_left] = '0;
      m_clr_left--;
    end else begin
      if (fifo_ne) begin
        w = m_fifo.pop_front();
        m_mem[w.a] = w.d;
        if (m_wcnt < DEPTH) m_wcnt++;
      end else if (rv) begin
        m_rdq.push_back('{due: cyc + LAT, d: m_mem[ra]});
      end
      if (cs && !g) begin
        m_clr_left = DEPTH;
        m_wcnt = 0;
      end
    end
    if (hv) begin
      if (ha >= DW'(DEPTH)) m_aerr = 1'b1;
      else if (sz0 == FDEP) m_ovf = 1'b1;
      else m_fifo.push_back(wr_t'{a: ha[AW-1:0], d: hd});
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; hw_valid = 1'b0; clr_start = 1'b0; rd_req_valid = 1'b0; go = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_ready", 128'(rd_req_ready), 128'(0));
      chk("rst_mem_ce", 128'(mem_ce), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      @(posedge clk);
      #1;
      cyc++;
    end
    rst_n = 1'b1;
    m_fifo.delete();
    m_rdq.delete();
    m_clr_left = 0;
    m_ovf = 1'b0;
    m_aerr = 1'b0;
    m_wcnt = 0;
  endtask

  initial begin
    logic [DW-1:0] a, d;
    bit            g;
    for (int i = 0; i < DEPTH; i++) begin
      sram[i] = '0;
      m_mem[i] = '0;
    end
    do_reset(3);

    // Single write then read of address 5.
    step(1'b1, DW'(5), DW'(91'h1234), 1'b0, 1'b0, 1'b0, '0);
    idle(2);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, AW'(5));
    idle(LAT + 1);

    // Out-of-range addresses are dropped.
    step(1'b1, DW'(1024), rnd_data(), 1'b0, 1'b0, 1'b0, '0);
    a = '0;
    a[DW-1] = 1'b1;
    step(1'b1, a, rnd_data(), 1'b0, 1'b0, 1'b0, '0);
    idle(2);

    // Overflow while a clear is running, then drain in order.
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) step(1'b1, DW'(100 + i), rnd_data(), 1'b0, 1'b0, 1'b0, '0);
    idle(DEPTH + 4);
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, AW'(100 + i));
    idle(LAT + 1);

    // Clear request while the core runs is ignored.
    step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, '0);
    idle(3);

    // Read held while host writes are buffered.
    step(1'b1, DW'(8), rnd_data(), 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, DW'(7), DW'(91'hABC), 1'b0, 1'b0, 1'b1, AW'(7));
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, AW'(7));
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, AW'(7));
    idle(LAT + 1);

    // Eight back-to-back reads.
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, AW'(i));
    idle(LAT + 2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) a = DW'(DEPTH + $urandom_range(0, 5000));
      else a = DW'($urandom_range(0, 31));
      g = 1'(($urandom & 1) != 0);
      step(1'($urandom_range(0, 2) == 0), a, rnd_data(), g,
           g && ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           AW'($urandom_range(0, 31)));
    end
    idle(LAT + 2);

    // Reset in the middle of a clear, then a full clear and a read-back.
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
    idle(99);
    do_reset(2);
    idle(3);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
    idle(DEPTH + 2);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, AW'(5));
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, AW'(7));
    idle(LAT + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
